// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared encodings for the unified I/D memory arbiter
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Read data returned alongside bus_err when an access is abandoned.
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - BUSY cycle counter with expiry flag
module arb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q;

  // Expiry is flagged during the LIMIT-th enabled cycle after a clear.
  assign expired_o = en_i && (count_q == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (en_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter for a single-port unified memory
module unified_mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  output logic                  stall_if,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ready,
  output logic                  stall_mem,
  output logic                  bus_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;
  logic                  if_ready_q, dm_ready_q, bus_err_q;

  logic idle, busy, grant_d, grant_i, grant, grant_sel, tmo_expired;

  // The cycle carrying a ready pulse grants nobody, so a held request is not
  // re-served before the requester has had a chance to present its next access.
  always_comb begin
    idle      = (state_q == ST_IDLE);
    busy      = !idle;
    grant_d   = idle && !if_ready_q && !dm_ready_q && dm_req &&
                !(if_req && (streak_q == SW'(STARVE_LIMIT)));
    grant_i   = idle && !if_ready_q && !dm_ready_q && if_req && !grant_d;
    grant     = grant_d || grant_i;
    grant_sel = grant_d ? GRANT_D : GRANT_I;
    streak_d  = streak_q;
    if (grant_d) begin
      if (!if_req)                             streak_d = '0;
      else if (streak_q != SW'(STARVE_LIMIT))  streak_d = streak_q + 1'b1;
    end else if (grant_i) begin
      streak_d = '0;
    end
  end

  arb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (grant),
    .en_i     (busy),
    .expired_o(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      bus_err_q  <= 1'b0;
      streak_q   <= streak_d;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            mem_req_q <= 1'b1;
            if (grant_sel == GRANT_D) begin
              state_q     <= ST_BUSY_D;
              mem_we_q    <= dm_we;
              mem_addr_q  <= dm_addr;
              mem_wdata_q <= dm_wdata;
            end else begin
              state_q    <= ST_BUSY_I;
              mem_we_q   <= 1'b0;
              mem_addr_q <= if_addr;
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // An ack in the expiry cycle wins: it completes normally.
          if (mem_ack || tmo_expired) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
            bus_err_q <= !mem_ack;
            if (state_q == ST_BUSY_I) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= mem_ack ? mem_rdata : DATA_WIDTH'(ERR_RDATA);
            end else begin
              dm_ready_q <= 1'b1;
              dm_rdata_q <= mem_ack ? mem_rdata : DATA_WIDTH'(ERR_RDATA);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, stall_if, dm_ready, stall_mem, bus_err, mem_req, mem_we;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_arr [256];
  int          ack_delay;
  int          busy_cnt;
  logic        force_ack;
  logic [31:0] force_rdata;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .stall_if (stall_if),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ready (dm_ready),
    .stall_mem(stall_mem),
    .bus_err  (bus_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; the memory model answers ack_delay cycles after mem_req rises.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    if (mem_req) busy_cnt++;
    else         busy_cnt = 0;
    if (mem_req && ack_delay >= 0 && busy_cnt == ack_delay + 1) begin
      mem_ack = 1'b1;
      if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
      mem_rdata = mem_arr[mem_addr[9:2]];
    end
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = force_rdata;
    end
  endtask

  task automatic dm_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output logic err,
                        output logic we_seen);
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    lat      = 0;
    we_seen  = 1'b0;
    while (!dm_ready && lat < 40) begin
      tick();
      lat++;
      if (mem_req) we_seen = we_seen | mem_we;
    end
    rd     = dm_rdata;
    err    = bus_err;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        err, wes;
    logic [10:0] seq;
    int          ngrant;
    logic        prev;

    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[8'h04] = 32'hE3A0_0001;
    reset = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    mem_ack = 0; mem_rdata = 0; force_ack = 0; force_rdata = 0;
    ack_delay = 0; busy_cnt = 0;

    tick(); tick();
    check_eq("rst_mem_req",  {31'b0, mem_req},  32'h0);
    check_eq("rst_readies",  {30'b0, if_ready, dm_ready}, 32'h0);
    check_eq("rst_bus_err",  {31'b0, bus_err},  32'h0);
    check_eq("rst_if_rdata", if_rdata, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    tick();

    // Isolated fetch, cycle by cycle.
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    check_eq("f0_stall_if", {31'b0, stall_if}, 32'h1);
    check_eq("f0_mem_req",  {31'b0, mem_req},  32'h0);
    tick();
    check_eq("f1_mem_req",  {31'b0, mem_req},  32'h1);
    check_eq("f1_mem_addr", mem_addr, 32'h10);
    check_eq("f1_mem_we",   {31'b0, mem_we},   32'h0);
    check_eq("f1_stall_if", {31'b0, stall_if}, 32'h1);
    tick();
    check_eq("f2_if_ready", {31'b0, if_ready}, 32'h1);
    check_eq("f2_if_rdata", if_rdata, 32'hE3A0_0001);
    check_eq("f2_stall_if", {31'b0, stall_if}, 32'h0);
    check_eq("f2_mem_req",  {31'b0, mem_req},  32'h0);
    if_req = 1'b0;
    tick();
    check_eq("f3_if_ready", {31'b0, if_ready}, 32'h0);

    // Store then load.
    dm_txn(1'b1, 32'h40, 32'hCAFE_F00D, rd, lat, err, wes);
    check_eq("st_lat",  lat, 2);
    check_eq("st_we",   {31'b0, wes}, 32'h1);
    dm_txn(1'b0, 32'h40, 32'h0, rd, lat, err, wes);
    check_eq("ld_lat",  lat, 2);
    check_eq("ld_we",   {31'b0, wes}, 32'h0);
    check_eq("ld_data", rd, 32'hCAFE_F00D);
    check_eq("ld_err",  {31'b0, err}, 32'h0);

    // Contention with both requests held against zero-wait memory.
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    seq = '0; ngrant = 0; prev = mem_req;
    for (int k = 0; k < 33; k++) begin
      tick();
      if (mem_req && !prev && ngrant < 11) begin
        seq = {seq[9:0], (mem_addr == 32'h200)};
        ngrant++;
      end
      prev = mem_req;
    end
    if_req = 1'b0; dm_req = 1'b0;
    check_eq("arb_ngrant", ngrant, 11);
    check_eq("arb_order",  {21'b0, seq}, {21'b0, 11'b11110111101});
    tick(); tick(); tick();

    // D read that is never acknowledged.
    ack_delay = -1;
    dm_txn(1'b0, 32'h80, 32'h0, rd, lat, err, wes);
    check_eq("tmo_lat",  lat, 9);
    check_eq("tmo_err",  {31'b0, err}, 32'h1);
    check_eq("tmo_data", rd, 32'h0);
    ack_delay = 0;
    dm_txn(1'b0, 32'h40, 32'h0, rd, lat, err, wes);
    check_eq("post_tmo_lat",  lat, 2);
    check_eq("post_tmo_data", rd, 32'hCAFE_F00D);
    check_eq("post_tmo_err",  {31'b0, err}, 32'h0);

    // Ack one cycle before expiry, then in the expiry cycle itself.
    ack_delay = 6;
    dm_txn(1'b0, 32'h40, 32'h0, rd, lat, err, wes);
    check_eq("late_lat", lat, 8);
    check_eq("late_err", {31'b0, err}, 32'h0);
    ack_delay = 7;
    dm_txn(1'b0, 32'h40, 32'h0, rd, lat, err, wes);
    check_eq("edge_lat",  lat, 9);
    check_eq("edge_err",  {31'b0, err}, 32'h0);
    check_eq("edge_data", rd, 32'hCAFE_F00D);

    // Reset during BUSY_I, stray ack two cycles after reset.
    ack_delay = -1;
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    check_eq("rb_mem_req1", {31'b0, mem_req}, 32'h1);
    reset = 1'b1;
    tick();
    check_eq("rb_mem_req2", {31'b0, mem_req}, 32'h0);
    reset = 1'b0; if_req = 1'b0;
    force_ack = 1'b1; force_rdata = 32'h1234_5678;
    tick();
    force_ack = 1'b0;
    tick();
    check_eq("rb_if_ready", {31'b0, if_ready}, 32'h0);
    check_eq("rb_if_rdata", if_rdata, 32'h0);
    check_eq("rb_mem_req3", {31'b0, mem_req}, 32'h0);
    check_eq("rb_bus_err",  {31'b0, bus_err}, 32'h0);
    ack_delay = 0;
    dm_txn(1'b0, 32'h10, 32'h0, rd, lat, err, wes);
    check_eq("rb_next_lat",  lat, 2);
    check_eq("rb_next_data", rd, 32'hE3A0_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
